stim_arbiter: RTL and testbench

Round-robin scheduler that turns the four conditioned stimulus sources (heal button, feed button, ultrasonic presence, MPU6050 tilt) into a single serialized event stream for the pet state machine. Each rising edge on a request line is latched as pending, granted one at a time in round-robin order over a valid/ready handshake, and followed by a programmable cooldown so the state machine and LCD sequencer never see bursts. It sits between the button/sensor front-ends and the pet state machine in the top level.

---
 rtl/stim_arbiter.sv | 147 ++++++++++++++
 tb/tb_stim_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_arbiter.sv
// Purpose : round-robin scheduler that serialises four stimulus sources (heal, feed,
//           ultrasonic, tilt) into one event stream, with cooldown after every accept.
// Latency : rising edge latched as pending on edge E1, offered (ev_valid) after E2.
// Backpr. : the offer is held until ev_ready; new edges keep latching as pending meanwhile.
// Ports   : clk/rst (async, active-high); req/req_en/ovf_clr/ev_ready in;
//           ev_valid/ev_id/pending/busy/ovf out, all registered.
module stim_arbiter #(
  parameter int COOLDOWN = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] req_en,
  input  logic       ovf_clr,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_id,
  output logic [3:0] pending,
  output logic       busy,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  // Value loaded on accept so that exactly COOLDOWN edges pass in S_COOL.
  localparam logic [CNT_W-1:0] CNT_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ptr;
  logic [3:0]       r_req_d;
  logic [3:0]       r_pending;
  logic             r_ovf;
  logic             r_valid;
  logic [1:0]       r_id;
  logic             r_busy;

  logic [3:0]       w_rise;
  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_grant;
  logic [3:0]       w_clr;
  logic             w_ovf_set;

  assign w_rise = req & ~r_req_d & req_en;

  // Round-robin search starting at r_ptr. Walking from the farthest candidate
  // back to r_ptr lets the nearest set bit overwrite the others.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (r_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found;
  assign w_clr   = w_grant ? (4'b0001 << w_win) : 4'b0000;

  // A rise only counts as an overflow if the bit stays pending; a rise on the
  // very edge its bit is granted simply re-arms the request.
  assign w_ovf_set = |(w_rise & r_pending & ~w_clr);

  // Edge detect, pending latch and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_d   <= 4'b0000;
      r_pending <= 4'b0000;
      r_ovf     <= 1'b0;
    end else begin
      r_req_d   <= req;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Grant / offer / cooldown sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd0;
      r_valid <= 1'b0;
      r_id    <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_win + 2'd1;
            r_busy  <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ev_ready) begin
            r_valid <= 1'b0;
            if (COOLDOWN == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_COOL;
            end
          end
        end
        S_COOL: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ev_valid = r_valid;
  assign ev_id    = r_id;
  assign pending  = r_pending;
  assign busy     = r_busy;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_stim_arbiter.sv
// Bench for stim_arbiter: two instances (cooldown 4 and cooldown 0) share one
// stimulus stream; a behavioural model predicts every output cycle by cycle,
// and directed scenarios pin specific values by hand.
module tb_stim_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_en;
  logic       ovf_clr;
  logic       ev_ready;

  logic [1:0]      vld;
  logic [1:0][1:0] id;
  logic [1:0][3:0] pend;
  logic [1:0]      bsy;
  logic [1:0]      ov;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stim_arbiter #(.COOLDOWN(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .req(req), .req_en(req_en), .ovf_clr(ovf_clr),
    .ev_ready(ev_ready), .ev_valid(vld[0]), .ev_id(id[0]), .pending(pend[0]),
    .busy(bsy[0]), .ovf(ov[0])
  );

  stim_arbiter #(.COOLDOWN(0), .CNT_W(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .req_en(req_en), .ovf_clr(ovf_clr),
    .ev_ready(ev_ready), .ev_valid(vld[1]), .ev_id(id[1]), .pending(pend[1]),
    .busy(bsy[1]), .ovf(ov[1])
  );

  task automatic chk(input int d, input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL dut%0d %s: got %0d, expected %0d", d, nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Each source is a pending flag; the arbiter is either offering, waiting out
  // a number of remaining cooldown edges, or free to grant.
  int       cd_len [2] = '{4, 0};
  bit [3:0] m_pend [2];
  bit [3:0] m_prev [2];
  bit       m_vld  [2];
  int       m_id   [2];
  int       m_ptr  [2];
  int       m_cd   [2];
  bit       m_ovf  [2];

  // At each negedge: compare the DUT against the model, then advance the model
  // with the inputs that the coming posedge will sample.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_pend[d] = 0; m_prev[d] = 0; m_vld[d] = 0; m_id[d] = 0;
          m_ptr[d]  = 0; m_cd[d]   = 0; m_ovf[d] = 0;
        end else begin
          int       g;
          bit [3:0] rise;
          bit       hit;
          chk(d, "ev_valid", int'(vld[d]),  int'(m_vld[d]));
          chk(d, "ev_id",    int'(id[d]),   m_id[d]);
          chk(d, "pending",  int'(pend[d]), int'(m_pend[d]));
          chk(d, "busy",     int'(bsy[d]),  int'(m_vld[d] || m_cd[d] > 0));
          chk(d, "ovf",      int'(ov[d]),   int'(m_ovf[d]));
          rise = req & ~m_prev[d] & req_en;
          g    = -1;
          if (m_vld[d]) begin
            if (ev_ready) begin
              m_vld[d] = 0;
              m_cd[d]  = cd_len[d];
            end
          end else if (m_cd[d] > 0) begin
            m_cd[d]--;
          end else if (m_pend[d] != 0) begin
            for (int k = 0; k < 4; k++)
              if (g < 0 && m_pend[d][(m_ptr[d] + k) % 4]) g = (m_ptr[d] + k) % 4;
            m_vld[d] = 1;
            m_id[d]  = g;
            m_ptr[d] = (g + 1) % 4;
          end
          hit = 0;
          for (int i = 0; i < 4; i++)
            if (rise[i] && m_pend[d][i] && i != g) hit = 1;
          if (g >= 0) m_pend[d][g] = 1'b0;
          m_pend[d] = m_pend[d] | rise;
          if (hit) m_ovf[d] = 1;
          else if (ovf_clr) m_ovf[d] = 0;
          m_prev[d] = req;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int       ids[$];
    int       n_acc;
    int       n_id;
    int       bad;
    bit [3:0] flip;

    rst = 1'b1; req = 4'b0; req_en = 4'hF; ovf_clr = 1'b0; ev_ready = 1'b0;
    step();
    step();
    chk(0, "rst_valid",   int'(vld[0]),  0);
    chk(0, "rst_id",      int'(id[0]),   0);
    chk(0, "rst_pending", int'(pend[0]), 0);
    chk(0, "rst_busy",    int'(bsy[0]),  0);
    chk(0, "rst_ovf",     int'(ov[0]),   0);
    rst = 1'b0;

    // Reset / latency, cooldown 4
    step();
    req = 4'b0010;
    step();
    chk(0, "lat_pending", int'(pend[0]), 2);
    chk(0, "lat_valid0",  int'(vld[0]),  0);
    step();
    chk(0, "lat_valid1",  int'(vld[0]),  1);
    chk(0, "lat_id",      int'(id[0]),   1);
    chk(0, "lat_pend0",   int'(pend[0]), 0);
    step();
    req = 4'b0000;
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk(0, "acc_valid", int'(vld[0]), 0);
    chk(0, "acc_busy",  int'(bsy[0]), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk(0, "cool_busy", int'(bsy[0]), 1);
    end
    step();
    chk(0, "cool_done", int'(bsy[0]), 0);

    // Round-robin, cooldown 0
    do_reset();
    ev_ready = 1'b1;
    req = 4'hF;
    ids.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (vld[1]) ids.push_back(int'(id[1]));
    end
    chk(1, "rr4_count", ids.size(), 4);
    if (ids.size() == 4) begin
      for (int i = 0; i < 4; i++) chk(1, "rr4_order", ids[i], i);
    end
    req = 4'b0000;
    step();
    req = 4'b1001;
    ids.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (vld[1]) ids.push_back(int'(id[1]));
    end
    chk(1, "rr2_count", ids.size(), 2);
    if (ids.size() == 2) begin
      chk(1, "rr2_first",  ids[0], 0);
      chk(1, "rr2_second", ids[1], 3);
    end
    req = 4'b0000;
    step();
    req = 4'b0010;
    for (int i = 0; i < 4; i++) step();
    req = 4'b0000;
    step();
    req = 4'b1001;
    ids.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (vld[1]) ids.push_back(int'(id[1]));
    end
    chk(1, "rr3_count", ids.size(), 2);
    if (ids.size() == 2) begin
      chk(1, "rr3_first",  ids[0], 3);
      chk(1, "rr3_second", ids[1], 0);
    end
    req = 4'b0000;
    ev_ready = 1'b0;

    // Overflow / merge, cooldown 4
    do_reset();
    req = 4'b0010; step(); step();
    req = 4'b0110; step();
    req = 4'b0010; step();
    req = 4'b0110; step();
    chk(0, "ovf_set",  int'(ov[0]),   1);
    chk(0, "ovf_pend", int'(pend[0]), 4);
    req = 4'b0000;
    ev_ready = 1'b1;
    n_acc = 0; n_id = 0;
    for (int i = 0; i < 30; i++) begin
      if (vld[0] && ev_ready) begin
        n_acc++;
        if (id[0] == 2'd2) n_id++;
      end
      step();
    end
    chk(0, "ovf_events", n_acc, 2);
    chk(0, "ovf_id2",    n_id,  1);
    ev_ready = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk(0, "ovf_clr", int'(ov[0]), 0);

    // Edge collision with grant, cooldown 4
    do_reset();
    req = 4'b0010; step(); step();
    req = 4'b0011; step();
    req = 4'b0000; step();
    ev_ready = 1'b1; step();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    req = 4'b0001;
    step();
    chk(0, "col_valid", int'(vld[0]),     1);
    chk(0, "col_id",    int'(id[0]),      0);
    chk(0, "col_pend",  int'(pend[0][0]), 1);
    chk(0, "col_ovf",   int'(ov[0]),      0);
    req = 4'b0000;
    ev_ready = 1'b1;
    n_acc = 0; n_id = 0;
    for (int i = 0; i < 20; i++) begin
      if (vld[0] && ev_ready) begin
        n_acc++;
        if (id[0] == 2'd0) n_id++;
      end
      step();
    end
    chk(0, "col_events", n_acc, 2);
    chk(0, "col_id0",    n_id,  2);
    ev_ready = 1'b0;

    // Enable mask and long hold
    do_reset();
    req_en = 4'b1110;
    req = 4'b0001; step(); step(); step();
    chk(0, "en_pend",  int'(pend[0]), 0);
    chk(0, "en_valid", int'(vld[0]),  0);
    req = 4'b0000;
    req_en = 4'hF;
    step();
    req = 4'b1000; step(); step();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(vld[0] && id[0] == 2'd3)) bad++;
      step();
    end
    chk(0, "hold_stable", bad, 0);
    req = 4'b0000;
    ev_ready = 1'b1; step();
    ev_ready = 1'b0;

    // Async reset inside cooldown
    do_reset();
    req = 4'b0010; step(); step();
    ev_ready = 1'b1; step();
    ev_ready = 1'b0;
    req = 4'b1000; step();
    chk(0, "ar_pend", int'(pend[0]), 8);
    chk(0, "ar_busy", int'(bsy[0]),  1);
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk(0, "ar_valid",   int'(vld[0]),  0);
    chk(0, "ar_pending", int'(pend[0]), 0);
    chk(0, "ar_busy0",   int'(bsy[0]),  0);
    chk(0, "ar_ovf",     int'(ov[0]),   0);
    chk(0, "ar_id",      int'(id[0]),   0);
    step();
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vld[0]) bad++;
    end
    chk(0, "ar_no_event", bad, 0);

    // Randomised traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
      req      = req ^ flip;
      req_en   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      ev_ready = ($urandom_range(0, 1) == 1);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
